stream_demux: RTL and testbench

- Parametrised, registered 1:N stream demultiplexer; successor to the combinational 1:4 demux.
- Routes each accepted input beat to one selected output channel, or to all channels in broadcast mode.
- Each channel has a one-entry output register with valid/ready backpressure.
- Illegal selects are counted and flagged.
- Sits between a single producer and NUM_CH independent consumers.

---
 rtl/stream_demux_pkg.sv | 18 +
 rtl/demux_slot.sv | 39 +++
 rtl/stream_demux.sv | 95 +++++++++
 tb/tb_stream_demux.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the registered 1:N stream demultiplexer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stream_demux_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DW     = 8;
  localparam int DEF_CW     = 8;

  // Increment val, clamping at the largest value representable in 'width' bits.
  // Works on a 32-bit container so one helper serves any counter up to 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel.
// Latency: a load appears on valid/dout on the next rising edge.
// Backpressure: holds dout while valid & ~ready; free lets a new load in when empty or popping.
// Ports: clk, rst (async, active high); load/din from the demux; ready from the consumer;
//        valid/dout to the consumer; free back to the demux for in_ready computation.
module demux_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic          free
);

  logic pop;

  // Free when empty, or when the current occupant leaves on this edge.
  assign free = ~valid | ready;
  assign pop  = valid & ready;

  // The demux only raises load when free is high, so a load never overwrites
  // an unconsumed beat. Load and pop on the same edge reloads without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1:N stream demultiplexer with unicast/broadcast routing and illegal-select accounting.
// Latency: 1 cycle from accept to out_valid/out_data.
// Backpressure: in_ready follows the selected slot (all slots for broadcast); out_ready -> in_ready is combinational.
// Ports: clk, rst (async, active high); in_valid/in_ready/in_data/in_sel/in_bcast producer side;
//        out_valid/out_ready/out_data per-channel consumer side (channel k at [k*DW +: DW]);
//        err_clr clears err_sel (sticky illegal-select flag) and drop_cnt (saturating drop count).
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int DW     = DEF_DW,
  parameter  int CW     = DEF_CW,
  localparam int SW     = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic [SW-1:0]        in_sel,
  input  logic                 in_bcast,
  output logic [NUM_CH-1:0]    out_valid,
  output logic [NUM_CH*DW-1:0] out_data,
  input  logic [NUM_CH-1:0]    out_ready,
  input  logic                 err_clr,
  output logic                 err_sel,
  output logic [CW-1:0]        drop_cnt
);

  logic [NUM_CH-1:0] slot_free;
  logic [NUM_CH-1:0] slot_load;
  logic              sel_legal;
  logic              sel_free;
  logic              accept;
  logic              drop;
  logic [CW-1:0]     drop_cnt_inc;

  // Out-of-range selects only exist when NUM_CH is not a power of two.
  // The extra bit keeps the comparison exact for NUM_CH == 2**SW.
  assign sel_legal = ({1'b0, in_sel} < (SW+1)'(NUM_CH));

  always_comb begin
    sel_free = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (in_sel == SW'(k)) sel_free = slot_free[k];
    end
  end

  // Illegal unicast beats are always taken so a bad select cannot wedge the producer.
  // in_ready depends only on select/broadcast and slot state, never on in_valid.
  assign in_ready = in_bcast  ? (&slot_free) :
                    sel_legal ? sel_free     : 1'b1;

  assign accept = in_valid & in_ready;
  assign drop   = accept & ~in_bcast & ~sel_legal;

  always_comb begin
    slot_load = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      slot_load[k] = accept & (in_bcast | (in_sel == SW'(k)));
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .DW(DW)
    ) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (slot_load[k]),
      .din  (in_data),
      .ready(out_ready[k]),
      .valid(out_valid[k]),
      .dout (out_data[k*DW +: DW]),
      .free (slot_free[k])
    );
  end

  assign drop_cnt_inc = CW'(sat_inc(32'(drop_cnt), CW));

  // A drop in the same cycle as err_clr is counted after the clear, so it survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sel  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      err_sel  <= 1'b1;
      drop_cnt <= err_clr ? CW'(1) : drop_cnt_inc;
    end else if (err_clr) begin
      err_sel  <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        in_valid4, in_ready4, in_bcast4, err_clr4, err_sel4;
  logic [7:0]  in_data4, drop_cnt4;
  logic [1:0]  in_sel4;
  logic [3:0]  out_valid4, out_ready4;
  logic [31:0] out_data4;

  // 3-channel instance (has one illegal select value)
  logic        in_valid3, in_ready3, in_bcast3, err_clr3, err_sel3;
  logic [7:0]  in_data3, drop_cnt3;
  logic [1:0]  in_sel3;
  logic [2:0]  out_valid3, out_ready3;
  logic [23:0] out_data3;

  stream_demux #(.NUM_CH(4), .DW(8), .CW(8)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .in_sel(in_sel4), .in_bcast(in_bcast4),
    .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready4),
    .err_clr(err_clr4), .err_sel(err_sel4), .drop_cnt(drop_cnt4)
  );

  stream_demux #(.NUM_CH(3), .DW(8), .CW(8)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .in_sel(in_sel3), .in_bcast(in_bcast3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ready(out_ready3),
    .err_clr(err_clr3), .err_sel(err_sel3), .drop_cnt(drop_cnt3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp4 [4][$];
  logic [7:0] exp3 [3][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the drive point: just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard producer: every beat the DUT takes pushes its expected deliveries.
  always @(negedge clk) begin
    if (!rst && in_valid4 && in_ready4) begin
      if (in_bcast4) begin
        for (int k = 0; k < 4; k++) exp4[k].push_back(in_data4);
      end else begin
        exp4[in_sel4].push_back(in_data4);
      end
    end
    if (!rst && in_valid3 && in_ready3) begin
      if (in_bcast3) begin
        for (int k = 0; k < 3; k++) exp3[k].push_back(in_data3);
      end else if (int'(in_sel3) < 3) begin
        exp3[int'(in_sel3)].push_back(in_data3);
      end
    end
  end

  // Scoreboard monitor: each handshake on an output channel consumes one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid4[k] && out_ready4[k]) begin
          if (exp4[k].size() == 0)
            check($sformatf("mon4_unexpected_ch%0d", k), 32'(out_data4[k*8 +: 8]), 32'hFFFF_FFFF);
          else
            check($sformatf("mon4_data_ch%0d", k), 32'(out_data4[k*8 +: 8]), 32'(exp4[k].pop_front()));
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (out_valid3[k] && out_ready3[k]) begin
          if (exp3[k].size() == 0)
            check($sformatf("mon3_unexpected_ch%0d", k), 32'(out_data3[k*8 +: 8]), 32'hFFFF_FFFF);
          else
            check($sformatf("mon3_data_ch%0d", k), 32'(out_data3[k*8 +: 8]), 32'(exp3[k].pop_front()));
        end
      end
    end
  end

  // Producer-side protocol rule on the 4-channel port: a blocked beat stays put.
  logic        pend_q = 1'b0;
  logic [10:0] hold_q = '0;
  always @(negedge clk) begin
    if (!rst && pend_q && (!in_valid4 || ({in_data4, in_sel4, in_bcast4} != hold_q))) begin
      n_fail++;
      $display("FAIL upstream_stable: blocked beat changed to 0x%0h, held 0x%0h", {in_data4, in_sel4, in_bcast4}, hold_q);
    end
    pend_q = !rst && in_valid4 && !in_ready4;
    hold_q = {in_data4, in_sel4, in_bcast4};
  end

  initial begin
    in_valid4 = 0; in_data4 = 0; in_sel4 = 0; in_bcast4 = 0; out_ready4 = 4'hF; err_clr4 = 0;
    in_valid3 = 0; in_data3 = 0; in_sel3 = 0; in_bcast3 = 0; out_ready3 = 3'h7; err_clr3 = 0;

    // Reset state
    #2;
    check("rst_out_valid4", 32'(out_valid4), 32'h0);
    check("rst_out_data4", out_data4, 32'h0);
    check("rst_err_sel4", 32'(err_sel4), 32'h0);
    check("rst_drop_cnt4", 32'(drop_cnt4), 32'h0);
    check("rst_out_valid3", 32'(out_valid3), 32'h0);
    cyc();
    cyc();
    rst = 0;
    cyc();

    // Unicast sweep: one beat per cycle, each lands on its channel one edge later
    for (int i = 0; i < 4; i++) begin
      in_valid4 = 1; in_sel4 = 2'(i); in_data4 = 8'hA0 + 8'(i);
      @(negedge clk);
      check($sformatf("sweep_in_ready_%0d", i), 32'(in_ready4), 32'h1);
      cyc();
      check($sformatf("sweep_valid_%0d", i), 32'(out_valid4), 32'h1 << i);
      check($sformatf("sweep_data_%0d", i), 32'(out_data4[i*8 +: 8]), 32'hA0 + i);
    end
    in_valid4 = 0;
    cyc();
    check("sweep_drained", 32'(out_valid4), 32'h0);

    // Backpressure on ch2; ch1 keeps flowing
    out_ready4 = 4'b1011;
    in_valid4 = 1; in_sel4 = 2; in_data4 = 8'h11;
    @(negedge clk);
    check("bp_first_ready", 32'(in_ready4), 32'h1);
    cyc();
    in_sel4 = 1; in_data4 = 8'h33;
    @(negedge clk);
    check("bp_other_ch_ready", 32'(in_ready4), 32'h1);
    cyc();
    check("bp_ch2_held", 32'(out_data4[23:16]), 32'h11);
    check("bp_ch1_loaded", 32'(out_valid4), 32'b0110);
    in_sel4 = 2; in_data4 = 8'h22;
    @(negedge clk);
    check("bp_second_blocked", 32'(in_ready4), 32'h0);
    cyc();
    @(negedge clk);
    check("bp_still_blocked", 32'(in_ready4), 32'h0);
    check("bp_stall_stable", 32'(out_data4[23:16]), 32'h11);
    cyc();
    out_ready4 = 4'hF;
    @(negedge clk);
    check("bp_ready_via_pop", 32'(in_ready4), 32'h1);
    cyc();
    check("bp_no_bubble_valid", 32'(out_valid4[2]), 32'h1);
    check("bp_no_bubble_data", 32'(out_data4[23:16]), 32'h22);
    in_valid4 = 0;
    cyc();
    check("bp_drained", 32'(out_valid4), 32'h0);

    // Broadcast waits for the full ch2 slot to pop
    out_ready4 = 4'b1011;
    in_valid4 = 1; in_sel4 = 2; in_data4 = 8'h44;
    cyc();
    in_bcast4 = 1; in_sel4 = 0; in_data4 = 8'h5A;
    @(negedge clk);
    check("bc_blocked", 32'(in_ready4), 32'h0);
    cyc();
    check("bc_only_ch2", 32'(out_valid4), 32'b0100);
    @(negedge clk);
    check("bc_still_blocked", 32'(in_ready4), 32'h0);
    cyc();
    out_ready4 = 4'hF;
    @(negedge clk);
    check("bc_ready", 32'(in_ready4), 32'h1);
    cyc();
    check("bc_all_valid", 32'(out_valid4), 32'hF);
    check("bc_all_data", out_data4, 32'h5A5A_5A5A);
    in_valid4 = 0; in_bcast4 = 0;
    cyc();
    check("bc_drained", 32'(out_valid4), 32'h0);

    // Async reset mid-stream with ch0 and ch3 full
    out_ready4 = 4'b0110;
    in_valid4 = 1; in_sel4 = 0; in_data4 = 8'h01;
    cyc();
    in_sel4 = 3; in_data4 = 8'h03;
    cyc();
    in_valid4 = 0;
    check("ar_pre_full", 32'(out_valid4), 32'b1001);
    #1;
    rst = 1;
    for (int k = 0; k < 4; k++) exp4[k].delete();
    #1;
    check("ar_valid_cleared", 32'(out_valid4), 32'h0);
    check("ar_data_cleared", out_data4, 32'h0);
    cyc();
    rst = 0;
    out_ready4 = 4'hF;
    cyc();
    in_valid4 = 1; in_sel4 = 0; in_data4 = 8'hC0;
    @(negedge clk);
    check("ar_post_ready", 32'(in_ready4), 32'h1);
    cyc();
    in_valid4 = 0;
    check("ar_post_valid", 32'(out_valid4), 32'b0001);
    check("ar_post_data", 32'(out_data4[7:0]), 32'hC0);
    cyc();
    check("ar_post_drained", 32'(out_valid4), 32'h0);

    // Illegal select on the 3-channel instance, run into saturation
    in_valid3 = 1; in_sel3 = 3; in_data3 = 8'h77;
    @(negedge clk);
    check("ill_in_ready", 32'(in_ready3), 32'h1);
    cyc();
    check("ill_no_out", 32'(out_valid3), 32'h0);
    check("ill_err_sel", 32'(err_sel3), 32'h1);
    check("ill_cnt_1", 32'(drop_cnt3), 32'd1);
    repeat (253) cyc();
    check("ill_cnt_254", 32'(drop_cnt3), 32'd254);
    cyc();
    check("ill_cnt_255", 32'(drop_cnt3), 32'd255);
    repeat (45) cyc();
    check("ill_cnt_sat", 32'(drop_cnt3), 32'd255);
    check("ill_no_out_after", 32'(out_valid3), 32'h0);

    // err_clr colliding with an illegal accept, then err_clr alone
    err_clr3 = 1;
    cyc();
    check("clr_collide_err", 32'(err_sel3), 32'h1);
    check("clr_collide_cnt", 32'(drop_cnt3), 32'd1);
    in_valid3 = 0;
    cyc();
    err_clr3 = 0;
    check("clr_alone_err", 32'(err_sel3), 32'h0);
    check("clr_alone_cnt", 32'(drop_cnt3), 32'd0);

    // Legal traffic on the 3-channel instance still routes normally
    in_valid3 = 1; in_sel3 = 1; in_data3 = 8'h31;
    cyc();
    in_valid3 = 0;
    check("ch3_legal_valid", 32'(out_valid3), 32'b010);
    check("ch3_legal_data", 32'(out_data3[15:8]), 32'h31);
    check("ch3_legal_cnt", 32'(drop_cnt3), 32'd0);
    cyc();
    cyc();

    for (int k = 0; k < 4; k++) check($sformatf("sb4_empty_ch%0d", k), 32'(exp4[k].size()), 32'd0);
    for (int k = 0; k < 3; k++) check($sformatf("sb3_empty_ch%0d", k), 32'(exp3[k].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
